// File: rtl/square_wave_sequencer.sv
// square_wave_sequencer
//    Steps an external square-wave generator through a table of segments.
//    Each slot holds {period, duration, bypass}. A run walks slots
//    0..num_seg-1 (optionally looping). Each slot gets one LOAD cycle with
//    the generator disabled and then `dur` cycles enabled. The low cycle
//    between slots restarts the generator phase.
//
//    Ports
//       clk, reset_n          clock, async active-low reset
//       cfg_we/addr/period/dur/bypass   slot table write (IDLE only)
//       num_seg, loop         run length and repeat, sampled on start
//       start, abort          run control; abort wins over everything
//       busy, done, cfg_err   status (done/cfg_err are one-cycle pulses)
//       seg_idx               slot currently driven
//       gen_enable, gen_bypass, gen_T   generator controls
//
//    state | meaning
//    ------+--------------------------------------------------
//    IDLE  | waiting for start, table writable, generator off
//    LOAD  | one cycle: present slot period/bypass, load timer
//    RUN   | generator enabled until the duration timer expires
//    DONE  | one cycle: done pulse, then back to IDLE
module square_wave_sequencer #(
   parameter int NSEG  = 4,
   parameter int DUR_W = 16,
   localparam int AW   = (NSEG > 1) ? $clog2(NSEG) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [15:0]      cfg_period,
   input  logic [DUR_W-1:0] cfg_dur,
   input  logic             cfg_bypass,
   input  logic [AW:0]      num_seg,
   input  logic             loop,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             cfg_err,
   output logic [AW-1:0]    seg_idx,
   output logic             gen_enable,
   output logic             gen_bypass,
   output logic [15:0]      gen_T
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [AW:0]      NSEG_V  = (AW+1)'(NSEG);
   localparam logic [AW:0]      NUM_ONE = 1;
   localparam logic [AW-1:0]    IDX_ONE = 1;
   localparam logic [DUR_W-1:0] DUR_ONE = 1;

   logic [15:0]      period_q [NSEG];
   logic [DUR_W-1:0] dur_q    [NSEG];
   logic             byp_q    [NSEG];

   logic [1:0]       state_q, state_d;
   logic [AW-1:0]    seg_idx_q, seg_idx_d;
   logic [AW:0]      num_seg_q, num_seg_d;
   logic             loop_q, loop_d;
   logic [DUR_W-1:0] cnt_q, cnt_d;
   logic [15:0]      gen_T_q, gen_T_d;
   logic             gen_bypass_q, gen_bypass_d;
   logic             cfg_err_q, cfg_err_d;
   logic             busy_q, done_q, gen_enable_q;
   logic             start_ok, last_seg;
   logic [DUR_W-1:0] slot_dur;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NSEG; i++) begin
            period_q[i] <= '0;
            dur_q[i]    <= '0;
            byp_q[i]    <= 1'b0;
         end
      end else if (cfg_we && state_q == S_IDLE) begin
         period_q[cfg_addr] <= cfg_period;
         dur_q[cfg_addr]    <= cfg_dur;
         byp_q[cfg_addr]    <= cfg_bypass;
      end
   end

   assign start_ok = (num_seg != '0) && (num_seg <= NSEG_V);
   assign last_seg = ({1'b0, seg_idx_q} == (num_seg_q - NUM_ONE));
   // A zero duration still gives the slot one enabled cycle.
   assign slot_dur = (dur_q[seg_idx_q] == '0) ? DUR_ONE : dur_q[seg_idx_q];

   always_comb begin
      state_d      = state_q;
      seg_idx_d    = seg_idx_q;
      num_seg_d    = num_seg_q;
      loop_d       = loop_q;
      cnt_d        = cnt_q;
      gen_T_d      = gen_T_q;
      gen_bypass_d = gen_bypass_q;
      cfg_err_d    = cfg_we && (state_q != S_IDLE);
      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  if (start_ok) begin
                     state_d   = S_LOAD;
                     seg_idx_d = '0;
                     num_seg_d = num_seg;
                     loop_d    = loop;
                  end else begin
                     cfg_err_d = 1'b1;
                  end
               end
            end
            S_LOAD: begin
               state_d      = S_RUN;
               gen_T_d      = period_q[seg_idx_q];
               gen_bypass_d = byp_q[seg_idx_q];
               cnt_d        = slot_dur;
            end
            S_RUN: begin
               if (cnt_q > DUR_ONE) begin
                  cnt_d = cnt_q - DUR_ONE;
               end else begin
                  cnt_d = '0;
                  if (!last_seg) begin
                     seg_idx_d = seg_idx_q + IDX_ONE;
                     state_d   = S_LOAD;
                  end else if (loop_q) begin
                     seg_idx_d = '0;
                     state_d   = S_LOAD;
                  end else begin
                     state_d   = S_DONE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Status outputs are decoded from the next state so they line up with
   // the state register while still coming straight out of flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         seg_idx_q    <= '0;
         num_seg_q    <= '0;
         loop_q       <= 1'b0;
         cnt_q        <= '0;
         gen_T_q      <= '0;
         gen_bypass_q <= 1'b0;
         cfg_err_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         gen_enable_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         seg_idx_q    <= seg_idx_d;
         num_seg_q    <= num_seg_d;
         loop_q       <= loop_d;
         cnt_q        <= cnt_d;
         gen_T_q      <= gen_T_d;
         gen_bypass_q <= gen_bypass_d;
         cfg_err_q    <= cfg_err_d;
         busy_q       <= (state_d != S_IDLE);
         done_q       <= (state_d == S_DONE);
         gen_enable_q <= (state_d == S_RUN);
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign cfg_err    = cfg_err_q;
   assign seg_idx    = seg_idx_q;
   assign gen_enable = gen_enable_q;
   assign gen_bypass = gen_bypass_q;
   assign gen_T      = gen_T_q;

endmodule

// File: doc/square_wave_sequencer.md
SQUARE_WAVE_SEQUENCER -- requirements
Module: square_wave_sequencer

Interface
REQ-001 Parameter NSEG, default 4: number of segment slots; power of two, 2..16.
REQ-002 Parameter DUR_W, default 16: width of segment duration field.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cfg_we  in  1  segment slot write strobe.
REQ-006 cfg_addr  in  log2(NSEG)  slot index for write.
REQ-007 cfg_period  in  16  square-wave period value T for slot.
REQ-008 cfg_dur  in  DUR_W  segment duration in clk cycles.
REQ-009 cfg_bypass  in  1  slot selects clock bypass instead of divided output.
REQ-010 num_seg  in  log2(NSEG)+1  active slot count, sampled at start.
REQ-011 loop  in  1  repeat sequence, sampled at start.
REQ-012 start  in  1  start pulse.
REQ-013 abort  in  1  stop request.
REQ-014 busy  out  1  high in any state except IDLE.
REQ-015 done  out  1  one-cycle pulse on normal completion.
REQ-016 cfg_err  out  1  one-cycle pulse when cfg_we or start is rejected.
REQ-017 seg_idx  out  log2(NSEG)  slot currently driven.
REQ-018 gen_enable  out  1  to square-wave generator enable.
REQ-019 gen_bypass  out  1  to square-wave generator bypass.
REQ-020 gen_T  out  16  to square-wave generator period input.

Function
REQ-021 Slot table: NSEG entries {period, dur, bypass}; written on cfg_we only in IDLE; cfg_we in any other state is ignored and pulses cfg_err next cycle.
REQ-022 FSM states IDLE, LOAD, RUN, DONE; all outputs registered.
REQ-023 IDLE: gen_enable=0; start with 1<=num_seg<=NSEG -> LOAD, latch num_seg and loop, seg_idx=0.
REQ-024 start in IDLE with num_seg=0 or num_seg>NSEG: stay IDLE, cfg_err pulse; start while busy ignored, no cfg_err.
REQ-025 LOAD: exactly one cycle; gen_enable=0; gen_T, gen_bypass updated from slot[seg_idx]; duration counter loaded with slot dur (dur=0 treated as 1); -> RUN.
REQ-026 RUN: gen_enable=1 for exactly dur cycles; gen_T/gen_bypass held constant.
REQ-027 RUN end, seg_idx < num_seg-1: seg_idx+1, -> LOAD (one-cycle enable-low gap restarts generator phase).
REQ-028 RUN end, last slot, loop=1: seg_idx=0, -> LOAD; loop=0: -> DONE.
REQ-029 DONE: one cycle, done=1, gen_enable=0, -> IDLE.
REQ-030 abort in LOAD/RUN/DONE: -> IDLE next cycle, gen_enable=0, no done pulse; abort has priority over all transitions; abort in IDLE no effect.
REQ-031 start and abort same cycle in IDLE: abort wins, stay IDLE.
REQ-032 Duration counter DUR_W bits, decrements, no wrap; slot table changes during run impossible (REQ-021).

Reset
REQ-033 reset_n low: FSM=IDLE, busy=done=cfg_err=0, seg_idx=0, gen_enable=0, gen_bypass=0, gen_T=0, counter=0, slot table all zero; applies immediately mid-run.

Verification
REQ-034 Write slots 0:{T=3,dur=10,byp=0},1:{T=1,dur=5,byp=0}; num_seg=2, loop=0, start -> LOAD(1), enable 10 cycles T=3, LOAD(1), enable 5 cycles T=1, done pulse, busy low; total busy 18 cycles.
REQ-035 Same table, loop=1, start, abort after 30 cycles -> gen_enable=0 and busy=0 next cycle, no done; seg_idx sequence 0,1,0,1 before abort.
REQ-036 Slot 0 {T=5,dur=0,byp=1}, num_seg=1 -> gen_bypass=1, gen_enable high exactly 1 cycle, then done.
REQ-037 start with num_seg=0 -> cfg_err pulse, busy stays 0; cfg_we during RUN -> cfg_err pulse, slot unchanged on readback run.
REQ-038 reset_n asserted mid-RUN -> all outputs zero asynchronously; after release, start with num_seg=1 runs zeroed slot 0 (dur treated 1).
